// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: d = x - y - bin (mod 2^WIDTH), one bit per
// clock, LSB first. Operands are captured on start; the result, borrow-out and
// zero flag are published when the last bit has been processed.
module serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             zero
);

  // Counter only has to reach WIDTH-1; keep at least one bit for WIDTH == 1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] x_q, x_d;      // minuend, shifted right one bit per RUN cycle
  logic [WIDTH-1:0] y_q, y_d;      // subtrahend, shifted alongside x_q
  logic             br_q, br_d;    // running borrow
  logic [WIDTH-1:0] acc_q, acc_d;  // difference bits, filled from the MSB end
  logic [WIDTH-1:0] d_q, d_d;      // published result
  logic             bout_q, bout_d;

  logic             diff_bit;
  logic             br_next;
  logic             last_bit;
  logic [WIDTH-1:0] acc_shifted;

  // Full-subtractor cell on the current LSBs plus the shifted accumulator.
  always_comb begin
    diff_bit    = x_q[0] ^ y_q[0] ^ br_q;
    br_next     = (~x_q[0] & y_q[0]) | (~(x_q[0] ^ y_q[0]) & br_q);
    last_bit    = (cnt_q == CW'(WIDTH - 1));
    acc_shifted = (acc_q >> 1) | (WIDTH'(diff_bit) << (WIDTH - 1));
  end

  // Next-state and datapath update; every target holds its value by default.
  always_comb begin
    // NOTE: defaulting every _d to its _q first means no path leaves a signal
    // unassigned, so no latches are inferred and "hold" is the implicit case.
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    br_d    = br_q;
    acc_d   = acc_q;
    d_d     = d_q;
    bout_d  = bout_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = x;
          y_d     = y;
          br_d    = bin;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        x_d   = x_q >> 1;
        y_d   = y_q >> 1;
        br_d  = br_next;
        acc_d = acc_shifted;
        cnt_d = cnt_q + CW'(1);
        if (last_bit) begin
          // Final bit lands at d[WIDTH-1]; publish result with its borrow.
          d_d     = acc_shifted;
          bout_d  = br_next;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset aborts any operation immediately.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: operands, counter, borrow, accumulator and result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      br_q   <= 1'b0;
      acc_q  <= '0;
      d_q    <= '0;
      bout_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      x_q    <= x_d;
      y_q    <= y_d;
      br_q   <= br_d;
      acc_q  <= acc_d;
      d_q    <= d_d;
      bout_q <= bout_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign d    = d_q;
  assign bout = bout_q;
  // d_q only changes on entry to DONE, so zero follows the same timing.
  assign zero = (d_q == '0);

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: a scoreboard queue holds the
// expected result of every started operation; a monitor pops and compares it
// whenever the DUT raises done.
module tb_serial_subtractor;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] d;
    logic         bout;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bout;
  logic         zero;

  int           n_cmp;
  int           n_err;
  exp_t         sb_q[$];
  exp_t         mon_e;
  logic [W-1:0] last_d;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x),
    .y     (y),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest pending result.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", done, 1'b0);
      end else begin
        mon_e = sb_q.pop_front();
        check("d", d, mon_e.d);
        check("bout", bout, mon_e.bout);
        check("zero", zero, (mon_e.d == '0));
      end
    end
  end

  // One operation: wait for IDLE, issue start, scramble inputs after capture,
  // optionally pulse a spurious start during RUN, and check timing.
  task automatic run_op(input logic [W-1:0] xv, input logic [W-1:0] yv,
                        input logic bv, input int glitch);
    logic [W:0] full;
    int         lat;
    @(negedge clk);
    for (int i = 0; i < 4 * W && busy; i++) @(negedge clk);
    check("idle_before_start", busy, 1'b0);
    x     = xv;
    y     = yv;
    bin   = bv;
    start = 1'b1;
    full  = {1'b0, xv} - {1'b0, yv} - {{W{1'b0}}, bv};
    sb_q.push_back('{d: full[W-1:0], bout: full[W]});
    @(posedge clk);
    #1;
    start = 1'b0;
    x     = W'($urandom);
    y     = W'($urandom);
    bin   = 1'($urandom);
    check("busy_run", busy, 1'b1);
    lat = 0;
    for (int k = 1; k <= W + 4; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
      if (k == glitch) begin
        start = 1'b1;
        x     = 1;
        y     = 1;
        bin   = 1'b0;
      end
      if (k == W / 2) check("d_hold", d, last_d);
    end
    check("latency", lat, W);
    last_d = full[W-1:0];
    @(posedge clk);
    #1;
    check("done_pulse", done, 1'b0);
    check("busy_idle", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    last_d = '0;
    rst    = 1'b1;
    start  = 1'b0;
    x      = '0;
    y      = '0;
    bin    = 1'b0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_d", d, 0);
    check("rst_bout", bout, 1'b0);
    check("rst_zero", zero, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_op(16'd1009,  16'd56,    1'b0, -1);
    run_op(16'd0,     16'd1,     1'b0, -1);
    run_op(16'd2,     16'd65000, 1'b0, -1);
    run_op(16'd10000, 16'd7,     1'b1, -1);
    run_op(16'd108,   16'd108,   1'b0, -1);
    run_op(16'd108,   16'd108,   1'b1, -1);
    run_op(16'd65535, 16'd0,     1'b0, -1);
    run_op(16'd0,     16'd65535, 1'b1, -1);
    run_op(16'd300,   16'd700,   1'b0, 5);
    for (int i = 0; i < 6; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), -1);
    end

    // Abort mid-RUN: no result is queued, so any done would be flagged.
    @(negedge clk);
    x     = 16'd2490;
    y     = 16'd10;
    bin   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_d", d, 0);
    check("abort_zero", zero, 1'b1);
    check("abort_bout", bout, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("abort_hold_busy", busy, 1'b0);
    rst    = 1'b0;
    last_d = '0;
    run_op(16'd2490, 16'd10, 1'b0, -1);

    repeat (4) @(posedge clk);
    #1;
    check("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
